// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage access unit.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_RSP  = 2'd1,
    RMW_MERGE = 2'd2
  } state_e;

  // Encoding of the numberOfByte size flag on both the pipeline and memory side.
  localparam logic MEM_WORD = 1'b1;
  localparam logic MEM_BYTE = 1'b0;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/load_formatter.sv
// Shapes raw memory read data into the load result: words pass through,
// bytes are zero- or sign-extended from bit 7.
module load_formatter
  import mem_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] raw_data,
  input  logic              is_word,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] load_data
);

  // Select pass-through or extended low byte.
  always_comb begin
    if (is_word == MEM_WORD) begin
      load_data = raw_data;
    end else begin
      load_data = {{(DATA_W-BYTE_W){sign_ext & raw_data[BYTE_W-1]}}, raw_data[BYTE_W-1:0]};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: turns EX/MEM load/store requests into data-memory
// controls, performs byte stores as read-modify-write, formats load results
// and stalls the pipeline while a two-cycle access is outstanding.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_memRead,
  input  logic              ex_memWrite,
  input  logic              ex_numberOfByte,
  input  logic              ex_signExt,
  input  logic [ADDR_W-1:0] ex_address,
  input  logic [DATA_W-1:0] ex_storeData,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_loadData,
  output logic              mem_wrEnable,
  output logic              mem_rdEnable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_numberOfByte,
  input  logic [DATA_W-1:0] mem_out
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                word_q, word_d;
  logic                sext_q, sext_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic                wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [DATA_W-1:0]   fmt_data;
  logic                is_store, is_load;
  logic                wr_en, rd_en, stall_c;

  // A request with both memRead and memWrite set is a store; its read is dropped.
  assign is_store = ex_valid & ex_memWrite;
  assign is_load  = ex_valid & ex_memRead & ~ex_memWrite;

  load_formatter #(.DATA_W(DATA_W)) u_load_formatter (
    .raw_data  (mem_out),
    .is_word   (word_q),
    .sign_ext  (sext_q),
    .load_data (fmt_data)
  );

  // Next-state, latched request and raw memory controls.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d          = state_q;
    addr_d           = addr_q;
    word_d           = word_q;
    sext_d           = sext_q;
    byte_d           = byte_q;
    wb_valid_d       = 1'b0;
    wb_data_d        = wb_data_q;
    wr_en            = 1'b0;
    rd_en            = 1'b0;
    stall_c          = 1'b0;
    mem_address      = ex_address;
    mem_in           = ex_storeData;
    mem_numberOfByte = MEM_WORD;

    unique case (state_q)
      IDLE: begin
        if (is_store) begin
          if (ex_numberOfByte == MEM_WORD) begin
            wr_en = 1'b1;
          end else begin
            // Fetch the whole word so the neighbouring byte can be written back unchanged.
            rd_en   = 1'b1;
            addr_d  = ex_address;
            byte_d  = ex_storeData[BYTE_W-1:0];
            stall_c = 1'b1;
            state_d = RMW_MERGE;
          end
        end else if (is_load) begin
          rd_en            = 1'b1;
          mem_numberOfByte = ex_numberOfByte;
          addr_d           = ex_address;
          word_d           = ex_numberOfByte;
          sext_d           = ex_signExt;
          stall_c          = 1'b1;
          state_d          = LOAD_RSP;
        end
      end
      LOAD_RSP: begin
        mem_address      = addr_q;
        mem_numberOfByte = word_q;
        wb_data_d        = fmt_data;
        wb_valid_d       = 1'b1;
        state_d          = IDLE;
      end
      RMW_MERGE: begin
        wr_en       = 1'b1;
        mem_address = addr_q;
        mem_in      = {mem_out[DATA_W-1:BYTE_W], byte_q};
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // While reset is held the state is already IDLE, but ex_* may still request
  // an access, so the strobes and stall are masked explicitly.
  assign mem_wrEnable = wr_en & rst_n;
  assign mem_rdEnable = rd_en & rst_n;
  assign stall        = stall_c & rst_n;
  assign wb_valid     = wb_valid_q;
  assign wb_loadData  = wb_data_q;

  // State and latched request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      word_q     <= 1'b0;
      sext_q     <= 1'b0;
      byte_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      sext_q     <= sext_d;
      byte_q     <= byte_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed test-plan steps followed by
// randomized traffic, checked against a byte-array reference of memory contents.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_memRead = 1'b0, ex_memWrite = 1'b0;
  logic        ex_numberOfByte = 1'b0, ex_signExt = 1'b0;
  logic [15:0] ex_address = '0, ex_storeData = '0;
  logic        stall, wb_valid;
  logic [15:0] wb_loadData;
  logic        mem_wrEnable, mem_rdEnable, mem_numberOfByte;
  logic [15:0] mem_address, mem_in;
  logic [15:0] mem_out = '0;

  mem_access_unit #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid         (ex_valid),
    .ex_memRead       (ex_memRead),
    .ex_memWrite      (ex_memWrite),
    .ex_numberOfByte  (ex_numberOfByte),
    .ex_signExt       (ex_signExt),
    .ex_address       (ex_address),
    .ex_storeData     (ex_storeData),
    .stall            (stall),
    .wb_valid         (wb_valid),
    .wb_loadData      (wb_loadData),
    .mem_wrEnable     (mem_wrEnable),
    .mem_rdEnable     (mem_rdEnable),
    .mem_address      (mem_address),
    .mem_in           (mem_in),
    .mem_numberOfByte (mem_numberOfByte),
    .mem_out          (mem_out)
  );

  always #5 clk = ~clk;

  // Data memory: always writes two bytes, read data appears the cycle after issue.
  logic [7:0]  phys_mem [65536];
  logic [15:0] mem_addr_p1;
  assign mem_addr_p1 = mem_address + 16'd1;

  always @(posedge clk) begin
    if (mem_rdEnable)
      mem_out <= mem_numberOfByte ? {phys_mem[mem_addr_p1], phys_mem[mem_address]}
                                  : {8'h00, phys_mem[mem_address]};
    if (mem_wrEnable) begin
      phys_mem[mem_address] = mem_in[7:0];
      phys_mem[mem_addr_p1] = mem_in[15:8];
    end
  end

  int wb_cnt = 0, overlap_cnt = 0;
  always @(posedge clk) begin
    if (wb_valid) wb_cnt <= wb_cnt + 1;
    if (mem_wrEnable && mem_rdEnable) overlap_cnt <= overlap_cnt + 1;
  end

  // Reference model: architectural byte contents as the program sees them.
  logic [7:0]  ref_mem [65536];
  int          n_cmp = 0, n_bad = 0;
  logic        pend_wb = 1'b0;
  logic [15:0] pend_data = '0;

  function automatic logic [15:0] ref_load(input logic [15:0] a, input logic word, input logic sext);
    logic [15:0] a1 = a + 16'd1;
    logic [7:0]  b  = ref_mem[a];
    if (word) return {ref_mem[a1], b};
    return (sext && b >= 8'h80) ? 16'hFF00 + 16'(b) : 16'(b);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic s, input logic w, input logic r);
    check_bit({tag, "_stall"}, stall, s);
    check_bit({tag, "_wr"}, mem_wrEnable, w);
    check_bit({tag, "_rd"}, mem_rdEnable, r);
  endtask

  // Start of a cycle: the previous cycle's load result must show up exactly now.
  task automatic cycle_begin();
    @(negedge clk);
    check_bit("wb_valid", wb_valid, pend_wb);
    if (pend_wb) check("wb_loadData", wb_loadData, pend_data);
    pend_wb = 1'b0;
  endtask

  task automatic cycle_end();
    @(posedge clk);
    #1;
    ex_valid = 1'b0; ex_memRead = 1'b0; ex_memWrite = 1'b0;
  endtask

  // Scramble the request inputs; used where the unit must ignore them.
  task automatic scramble();
    ex_valid        = 1'($urandom_range(0, 1));
    ex_memRead      = 1'($urandom_range(0, 1));
    ex_memWrite     = 1'($urandom_range(0, 1));
    ex_numberOfByte = 1'($urandom_range(0, 1));
    ex_signExt      = 1'($urandom_range(0, 1));
    ex_address      = 16'($urandom);
    ex_storeData    = 16'($urandom);
  endtask

  task automatic do_idle();
    cycle_begin();
    scramble();
    if (ex_valid) begin ex_memRead = 1'b0; ex_memWrite = 1'b0; end
    #1;
    check_ctl("idle", 1'b0, 1'b0, 1'b0);
    cycle_end();
  endtask

  task automatic do_store(input logic [15:0] a, input logic [15:0] d, input logic word, input logic also_rd);
    logic [15:0] a1 = a + 16'd1;
    cycle_begin();
    ex_valid = 1'b1; ex_memWrite = 1'b1; ex_memRead = also_rd;
    ex_numberOfByte = word; ex_signExt = 1'($urandom_range(0, 1));
    ex_address = a; ex_storeData = d;
    #1;
    check("st_addr", mem_address, a);
    check_bit("st_nob", mem_numberOfByte, MEM_WORD);
    if (word) begin
      check_ctl("st_word", 1'b0, 1'b1, 1'b0);
      check("st_word_in", mem_in, d);
      ref_mem[a] = d[7:0];
      ref_mem[a1] = d[15:8];
      cycle_end();
    end else begin
      check_ctl("st_byte_rd", 1'b1, 1'b0, 1'b1);
      cycle_end();
      cycle_begin();
      scramble();
      #1;
      check_ctl("st_byte_wr", 1'b0, 1'b1, 1'b0);
      check("rmw_addr", mem_address, a);
      check("rmw_in", mem_in, {ref_mem[a1], d[7:0]});
      ref_mem[a] = d[7:0];
      cycle_end();
    end
  endtask

  task automatic do_load(input logic [15:0] a, input logic word, input logic sext);
    logic [15:0] exp;
    cycle_begin();
    ex_valid = 1'b1; ex_memRead = 1'b1; ex_memWrite = 1'b0;
    ex_numberOfByte = word; ex_signExt = sext;
    ex_address = a; ex_storeData = 16'($urandom);
    #1;
    check_ctl("ld_issue", 1'b1, 1'b0, 1'b1);
    check("ld_addr", mem_address, a);
    check_bit("ld_nob", mem_numberOfByte, word);
    exp = ref_load(a, word, sext);
    cycle_end();
    cycle_begin();
    scramble();
    #1;
    check_ctl("ld_rsp", 1'b0, 1'b0, 1'b0);
    pend_wb = 1'b1;
    pend_data = exp;
    cycle_end();
  endtask

  initial begin
    int wb_base;
    for (int i = 0; i < 65536; i++) begin
      phys_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    phys_mem[1] = 8'd1; phys_mem[2] = 8'd2; phys_mem[3] = 8'd3; phys_mem[4] = 8'd3;
    ref_mem[1]  = 8'd1; ref_mem[2]  = 8'd2; ref_mem[3]  = 8'd3; ref_mem[4]  = 8'd3;

    // Reset: a load request held during reset must not reach the memory.
    ex_valid = 1'b1; ex_memRead = 1'b1; ex_address = 16'h0001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_ctl("rst", 1'b0, 1'b0, 1'b0);
    check_bit("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_data", wb_loadData, 16'h0000);
    ex_valid = 1'b0; ex_memRead = 1'b0;
    rst_n = 1'b1;

    // Directed test-plan steps.
    do_load(16'h0001, MEM_WORD, 1'b0);
    do_idle();
    check("tp_word_load", wb_loadData, 16'h0201);
    do_load(16'h0003, MEM_BYTE, 1'b0);
    do_idle();
    check("tp_ubyte_load", wb_loadData, 16'h0003);
    do_store(16'h0002, 16'h12AB, MEM_BYTE, 1'b0);
    do_load(16'h0002, MEM_WORD, 1'b0);
    do_idle();
    check("tp_rmw_load", wb_loadData, 16'h03AB);
    check("tp_rmw_neighbour", 16'(phys_mem[3]), 16'h0003);
    do_store(16'h0008, 16'h80FF, MEM_WORD, 1'b0);
    do_load(16'h0008, MEM_BYTE, 1'b1);
    do_idle();
    check("tp_sbyte8", wb_loadData, 16'hFFFF);
    do_load(16'h0009, MEM_BYTE, 1'b1);
    do_idle();
    check("tp_sbyte9", wb_loadData, 16'hFF80);
    do_load(16'h0009, MEM_BYTE, 1'b0);
    do_idle();
    check("tp_ubyte9", wb_loadData, 16'h0080);

    // Back-to-back: stall 0,1,0,1,0,1,0 is checked cycle by cycle in the tasks.
    wb_base = wb_cnt;
    do_store(16'h000A, 16'hBEEF, MEM_WORD, 1'b0);
    do_load(16'h000A, MEM_WORD, 1'b0);
    do_store(16'h000B, 16'h0011, MEM_BYTE, 1'b1);
    do_load(16'h000A, MEM_WORD, 1'b0);
    do_idle();
    check("b2b_wb_pulses", 16'(wb_cnt - wb_base), 16'd2);
    check("b2b_last", wb_loadData, 16'h11EF);

    // Reset asserted during the merge cycle of a byte store.
    cycle_begin();
    ex_valid = 1'b1; ex_memWrite = 1'b1; ex_numberOfByte = MEM_BYTE;
    ex_address = 16'h0004; ex_storeData = 16'h0055;
    #1;
    check_ctl("rstmid_rd", 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_memWrite = 1'b0;
    #1;
    check_ctl("rstmid", 1'b0, 1'b0, 1'b0);
    check_bit("rstmid_wb_valid", wb_valid, 1'b0);
    check("rstmid_wb_data", wb_loadData, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid_mem4", 16'(phys_mem[4]), 16'h0003);
    do_load(16'h0004, MEM_WORD, 1'b0);
    do_idle();
    check("rstmid_reload", wb_loadData, 16'h0003);

    // Randomized traffic, including the wrap at 0xFFFF.
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      int kind;
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF - 16'($urandom_range(0, 1))
                                      : 16'($urandom_range(0, 15));
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: do_idle();
        1: do_store(a, 16'($urandom), MEM_WORD, 1'($urandom_range(0, 1)));
        2: do_store(a, 16'($urandom), MEM_BYTE, 1'($urandom_range(0, 1)));
        default: do_load(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      endcase
    end
    do_idle();
    for (int i = 0; i < 16; i++)
      check("final_mem", 16'(phys_mem[i]), 16'(ref_mem[i]));
    check("final_mem_ffff", 16'(phys_mem[16'hFFFF]), 16'(ref_mem[16'hFFFF]));
    check("no_enable_overlap", 16'(overlap_cnt), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage controller that sits between the EX/MEM pipeline register and the byte-addressed 16-bit data memory.
- Translates load/store requests into the memory's wrEnable/rdEnable/address/in/numberOfByte controls.
- Implements byte stores as read-modify-write, because the memory always writes two bytes.
- Formats load results with zero- or sign-extension.
- Stalls the pipeline while a multi-cycle access is in flight.

Parameters:
ADDR_W, 16, address width; memory-side address arithmetic wraps modulo 2^ADDR_W.
DATA_W, 16, data width; fixed at 2 bytes, the unit is not generic over byte count.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX/MEM slot holds a valid instruction
ex_memRead  in  1  load request
ex_memWrite  in  1  store request
ex_numberOfByte  in  1  1 = 16-bit access, 0 = 8-bit access
ex_signExt  in  1  byte load: 1 = sign-extend, 0 = zero-extend
ex_address  in  16  byte address
ex_storeData  in  16  store data; bits [7:0] only for byte stores
stall  out  1  hold EX/MEM and upstream stages this cycle
wb_valid  out  1  one-cycle pulse: wb_loadData is valid
wb_loadData  out  16  formatted load result, held until the next load completes
mem_wrEnable  out  1  to data memory
mem_rdEnable  out  1  to data memory
mem_address  out  16  to data memory
mem_in  out  16  to data memory
mem_numberOfByte  out  1  to data memory
mem_out  in  16  from data memory; valid in the cycle after a read is issued

Behaviour:
- Clock port is clk; reset port is rst_n. Reset is asynchronous and active-low.
- States: IDLE, LOAD_RSP, RMW_MERGE.
- Reset values: state = IDLE, stall = 0, wb_valid = 0, wb_loadData = 0x0000, latched request registers = 0.
- While rst_n = 0, mem_wrEnable and mem_rdEnable are forced to 0.
- Memory-side outputs are combinational from state, the latched request and the ex_* inputs.
- mem_wrEnable and mem_rdEnable are never both 1.
- IDLE, ex_valid = 0, or neither memRead nor memWrite: both enables 0, stall = 0.
- IDLE, word store (memWrite and numberOfByte = 1):
  - mem_wrEnable = 1, mem_address = ex_address, mem_in = ex_storeData.
  - stall = 0; stay in IDLE. Single-cycle operation.
- IDLE, load:
  - mem_rdEnable = 1, mem_address = ex_address, mem_numberOfByte = ex_numberOfByte.
  - Latch address, size and signExt; stall = 1; go to LOAD_RSP.
- LOAD_RSP:
  - stall = 0; ex_* inputs are ignored, since the same instruction is still in EX/MEM.
  - mem_out is formatted and registered into wb_loadData at the clock edge; wb_valid = 1 in the following cycle.
  - Return to IDLE.
  - Total: the load occupies EX/MEM for 2 cycles; the result is visible 2 cycles after acceptance.
- IDLE, byte store (memWrite and numberOfByte = 0):
  - Issue a 16-bit read at ex_address (mem_numberOfByte = 1).
  - Latch address and storeData[7:0]; stall = 1; go to RMW_MERGE.
- RMW_MERGE:
  - mem_wrEnable = 1 at the latched address, mem_in = {mem_out[15:8], latched byte}.
  - The byte at address+1 is rewritten unchanged.
  - stall = 0; return to IDLE.
- Formatting:
  - Word load: mem_out unchanged.
  - Byte load: {8{signExt & mem_out[7]}, mem_out[7:0]}.
- memRead and memWrite both set: treated as a store; the read is dropped.
- Address 0xFFFF: memory-side +1 wraps to 0x0000. No special handling in this unit.
- wb_valid pulses only for loads, never for stores.
- Reset asserted mid-operation (LOAD_RSP or RMW_MERGE):
  - Return to IDLE immediately; the pending write or response is discarded; no wb_valid.
  - For RMW_MERGE, memory is left unmodified.

Decomposition:
- Shared package mem_pkg:
  - State enum (IDLE, LOAD_RSP, RMW_MERGE).
  - Constants MEM_WORD = 1'b1 and MEM_BYTE = 1'b0.
  - BYTE_W = 8.
- One natural sub-module, load_formatter: combinational zero/sign extension of mem_out by size and signExt.
- The FSM and the latched request stay in the top module.

Test Plan:
- Memory preloaded with [1]=1, [2]=2, [3]=3, [4]=3. Word load at 0x0001 -> stall high 1 cycle, wb_valid pulse, wb_loadData = 0x0201.
- Byte load, unsigned, at 0x0003 -> wb_loadData = 0x0003; mem_numberOfByte = 0 in the issue cycle.
- Byte store 0xAB at 0x0002 -> read cycle then write cycle, mem_in = 0x03AB; a following word load at 0x0002 returns 0x03AB and [3] is still 3.
- Word store 0x80FF at 0x0008 -> no stall, single write. Then:
  - Signed byte load at 0x0008 -> 0xFFFF.
  - Signed byte load at 0x0009 -> 0xFF80.
  - Unsigned byte load at 0x0009 -> 0x0080.
- Back-to-back word store, load, byte store, load -> enables never overlap, stall pattern 0, 1, 0, 1, 0, 1, 0, and wb_valid pulses exactly twice.
- Byte store 0x55 at 0x0004 with rst_n pulled low during RMW_MERGE -> no write occurs, [4] stays 3, state returns to IDLE, all outputs at reset values.
